// File: rtl/timer_dev.sv
// rtl/timer_dev.sv - memory-mapped countdown timer with one-shot / auto-reload modes and masked irq
//
// Optional feature macro: TIMER_PRESCALE_EN (enables the PRESCALE register at offset 3).
//
// Ports:
//   clk    in   1   clock, all state on rising edge
//   rst    in   1   synchronous active-low reset
//   sel    in   1   device selected by the bridge, qualifies we
//   addr   in   2   word offset (0 CTRL, 1 PRESET, 2 COUNT, 3 PRESCALE)
//   we     in   1   write strobe
//   wdata  in   32  write data
//   rdata  out  32  combinational read data for addr
//   irq    out  1   irq_flag & CTRL.IM
module timer_dev #(
    parameter int PRESCALE_WIDTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sel,
    input  logic [1:0]  addr,
    input  logic        we,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq
);

    localparam logic [1:0] A_CTRL     = 2'd0;
    localparam logic [1:0] A_PRESET   = 2'd1;
    localparam logic [1:0] A_COUNT    = 2'd2;
    localparam logic [1:0] A_PRESCALE = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_CNT,
        S_INT
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [3:0]  r_ctrl;        // [0] EN, [2:1] MODE, [3] IM
    logic [31:0] r_preset;
    logic [31:0] r_count;
    logic [31:0] w_count_nxt;
    logic        r_irq_flag;

    logic        w_wr;
    logic        w_ctrl_wr;
    logic        w_en_clr;
    logic        w_irq_set;
    logic        w_irq_clr;
    logic        w_tick;
    logic [PRESCALE_WIDTH-1:0] w_ps;

    assign w_wr      = sel & we;
    assign w_ctrl_wr = w_wr & (addr == A_CTRL);

`ifdef TIMER_PRESCALE_EN
    logic [PRESCALE_WIDTH-1:0] r_ps;
    logic [PRESCALE_WIDTH-1:0] r_ps_cnt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_ps <= '0;
        end else if (w_wr && addr == A_PRESCALE) begin
            r_ps <= wdata[PRESCALE_WIDTH-1:0];
        end
    end

    // Down-counting divider: cleared in LOAD so the first CNT cycle ticks,
    // then reloaded with PS on each tick, giving a tick every PS+1 cycles and
    // expiry after E(3 + P*(PS+1)).
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_ps_cnt <= '0;
        end else if (r_state == S_LOAD) begin
            r_ps_cnt <= '0;
        end else if (r_state == S_CNT && r_ctrl[0]) begin
            if (w_tick) begin
                r_ps_cnt <= r_ps;
            end else begin
                r_ps_cnt <= r_ps_cnt - 1'b1;
            end
        end
    end

    assign w_ps   = r_ps;
    assign w_tick = (r_ps_cnt == '0);
`else
    assign w_ps   = '0;
    assign w_tick = 1'b1;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        w_en_clr    = 1'b0;
        w_irq_set   = 1'b0;
        w_irq_clr   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_ctrl[0]) begin
                    w_state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                w_count_nxt = r_preset;
                w_state_nxt = S_CNT;
            end
            S_CNT: begin
                if (!r_ctrl[0]) begin
                    w_state_nxt = S_IDLE;
                end else if (w_tick) begin
                    // Zero is tested before decrementing, so COUNT never wraps.
                    if (r_count == 32'd0) begin
                        w_state_nxt = S_INT;
                        w_irq_set   = 1'b1;
                    end else begin
                        w_count_nxt = r_count - 32'd1;
                    end
                end
            end
            S_INT: begin
                if (r_ctrl[2:1] == 2'd1) begin
                    w_irq_clr   = 1'b1;
                    w_state_nxt = S_LOAD;
                end else begin
                    w_en_clr    = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_count <= 32'd0;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
        end
    end

    // A CPU write to CTRL takes priority over the FSM's EN clear and flag update.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_ctrl     <= 4'd0;
            r_irq_flag <= 1'b0;
        end else begin
            if (w_ctrl_wr) begin
                r_ctrl <= wdata[3:0];
            end else if (w_en_clr) begin
                r_ctrl[0] <= 1'b0;
            end

            if (w_ctrl_wr) begin
                r_irq_flag <= 1'b0;
            end else if (w_irq_set) begin
                r_irq_flag <= 1'b1;
            end else if (w_irq_clr) begin
                r_irq_flag <= 1'b0;
            end
        end
    end

    // PRESET changes only affect COUNT at the next LOAD.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_preset <= 32'd0;
        end else if (w_wr && addr == A_PRESET) begin
            r_preset <= wdata;
        end
    end

    always_comb begin
        rdata = 32'd0;
        case (addr)
            A_CTRL:     rdata = {28'd0, r_ctrl};
            A_PRESET:   rdata = r_preset;
            A_COUNT:    rdata = r_count;
            A_PRESCALE: rdata = 32'(w_ps);
            default:    rdata = 32'd0;
        endcase
    end

    assign irq = r_irq_flag & r_ctrl[3];

endmodule

// File: tb/tb_timer_dev.sv
// tb/tb_timer_dev.sv - scoreboard-driven directed bench for timer_dev
module tb_timer_dev;

    logic        clk;
    logic        rst;
    logic        sel;
    logic [1:0]  addr;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        irq;

    int n_run;
    int n_fail;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t exp_q[$];

    timer_dev #(.PRESCALE_WIDTH(8)) dut (
        .clk   (clk),
        .rst   (rst),
        .sel   (sel),
        .addr  (addr),
        .we    (we),
        .wdata (wdata),
        .rdata (rdata),
        .irq   (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_v(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        exp_q.push_back(e);
    endtask

    task automatic check(input logic [31:0] obs);
        exp_t e;
        n_run++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL scoreboard_empty: observed %0h required an expectation", obs);
        end else begin
            e = exp_q.pop_front();
            assert (obs === e.val) else begin
                n_fail++;
                $error("FAIL %s: observed %0h expected %0h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        sel   = 1'b1;
        we    = 1'b1;
        addr  = a;
        wdata = d;
        step();
        sel   = 1'b0;
        we    = 1'b0;
        wdata = 32'd0;
    endtask

    task automatic rd_check(input string tag, input logic [1:0] a, input logic [31:0] v);
        expect_v(tag, v);
        addr = a;
        #1;
        check(rdata);
    endtask

    task automatic irq_check(input string tag, input logic v);
        expect_v(tag, {31'd0, v});
        check({31'd0, irq});
    endtask

    initial begin
        n_run  = 0;
        n_fail = 0;
        rst    = 1'b0;
        sel    = 1'b0;
        we     = 1'b0;
        addr   = 2'd0;
        wdata  = 32'd0;
        step();
        step();
        rst = 1'b1;

        // Reset state
        for (int a = 0; a < 4; a++) rd_check("rst_reg", 2'(a), 32'd0);
        irq_check("rst_irq", 1'b0);

        // Reset during a running auto-reload count
        wr(2'd1, 32'd50);
        wr(2'd0, 32'hB);
        repeat (5) step();
        rst = 1'b0;
        step();
        rst = 1'b1;
        for (int a = 0; a < 4; a++) rd_check("rst_mid_reg", 2'(a), 32'd0);
        irq_check("rst_mid_irq", 1'b0);
        repeat (5) step();
        rd_check("rst_idle_count", 2'd2, 32'd0);
        irq_check("rst_idle_irq", 1'b0);

        // Upper CTRL bits read as zero
        wr(2'd0, 32'hFFFF_FFF8);
        rd_check("ctrl_upper", 2'd0, 32'h8);
        wr(2'd0, 32'h0);

        // One-shot, PRESET=5: irq rises after E8 and holds
        wr(2'd1, 32'd5);
        wr(2'd0, 32'h9);
        for (int k = 1; k <= 10; k++) begin
            step();
            irq_check($sformatf("oneshot_irq_E%0d", k), (k >= 8));
        end
        rd_check("oneshot_ctrl", 2'd0, 32'h8);
        rd_check("oneshot_count", 2'd2, 32'd0);
        wr(2'd0, 32'h0);
        irq_check("oneshot_clr", 1'b0);
        step();

        // PRESET=0 fires after E3
        wr(2'd1, 32'd0);
        wr(2'd0, 32'h9);
        for (int k = 1; k <= 3; k++) begin
            step();
            irq_check($sformatf("p0_irq_E%0d", k), (k == 3));
        end
        wr(2'd0, 32'h0);
        irq_check("p0_clr", 1'b0);
        step();

        // Auto-reload, PRESET=3: pulse every 6 cycles, COUNT 3,2,1,0 between pulses
        wr(2'd1, 32'd3);
        wr(2'd0, 32'hB);
        for (int k = 1; k <= 18; k++) begin
            step();
            irq_check($sformatf("reload_irq_E%0d", k), (k % 6 == 0));
            if ((k >= 8 && k <= 11) || (k >= 14 && k <= 17))
                rd_check($sformatf("reload_count_E%0d", k), 2'd2, 32'(3 - ((k - 8) % 6)));
        end
        wr(2'd0, 32'h0);
        repeat (3) step();
        irq_check("reload_stop_irq", 1'b0);

        // Masked, PRESET=2: irq never rises, EN self-clears
        wr(2'd1, 32'd2);
        wr(2'd0, 32'h1);
        for (int k = 1; k <= 6; k++) begin
            step();
            irq_check($sformatf("masked_irq_E%0d", k), 1'b0);
        end
        rd_check("masked_ctrl", 2'd0, 32'h0);
        wr(2'd0, 32'h0);
        step();

        // Pause with EN cleared, COUNT write ignored
        wr(2'd1, 32'd100);
        wr(2'd0, 32'h9);
        repeat (9) step();
        wr(2'd0, 32'h8);
        repeat (4) step();
        rd_check("pause_count", 2'd2, 32'd92);
        irq_check("pause_irq", 1'b0);
        wr(2'd2, 32'd7);
        rd_check("ro_count", 2'd2, 32'd92);
        rd_check("pause_preset", 2'd1, 32'd100);

`ifdef TIMER_PRESCALE_EN
        // Prescale PS=1, PRESET=4: irq after E11, COUNT steps every second cycle
        wr(2'd3, 32'd1);
        rd_check("ps_reg", 2'd3, 32'd1);
        wr(2'd1, 32'd4);
        wr(2'd0, 32'h9);
        for (int k = 1; k <= 12; k++) begin
            step();
            irq_check($sformatf("ps_irq_E%0d", k), (k >= 11));
            if (k >= 3 && k <= 6)
                rd_check($sformatf("ps_count_E%0d", k), 2'd2, 32'(4 - ((k - 1) / 2)));
        end
`else
        // Without the prescaler, offset 3 ignores writes and reads zero
        wr(2'd3, 32'd5);
        rd_check("ps_absent", 2'd3, 32'd0);
`endif

        if (exp_q.size() != 0) begin
            n_run++;
            n_fail++;
            $display("FAIL scoreboard_leftover: observed %0d pending required 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
